// File: rtl/hack_uart_pkg.sv
// Shared definitions for the Hack serial link (word transmitter and receiver).
package hack_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/hack_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module hack_baud_tick
    import hack_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Free-running bit counter, held at zero while cleared and wrapping after the last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/hack_uart_tx.sv
// Sends each 16-bit Hack word as two back-to-back 8N1 bytes, low byte first.
module hack_uart_tx
    import hack_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy
);

    uart_state_e state_r, state_next_s;
    logic [2:0]  bit_cnt_r, bit_cnt_next_s;
    logic        byte_idx_r, byte_idx_next_s;
    logic [15:0] shift_r, shift_next_s;
    logic        tx_r, tx_next_s;
    logic        ready_r;
    logic        busy_r;
    logic        tick_s;
    logic        timer_clr_s;
    logic        accept_s;

    assign timer_clr_s = (state_r == IDLE);
    assign accept_s    = in_valid && ready_r;

    hack_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr_s),
        .tick (tick_s)
    );

    // Next-state logic; tx is computed one step ahead so the line changes on the transition edge.
    always_comb begin
        state_next_s    = state_r;
        bit_cnt_next_s  = bit_cnt_r;
        byte_idx_next_s = byte_idx_r;
        shift_next_s    = shift_r;
        tx_next_s       = 1'b1;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s    = START;
                    shift_next_s    = in;
                    byte_idx_next_s = 1'b0;
                    bit_cnt_next_s  = 3'd0;
                    tx_next_s       = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = DATA;
                    tx_next_s    = shift_r[0];
                end else begin
                    tx_next_s = 1'b0;
                end
            end
            DATA: begin
                // Shifting the whole word means byte 1 lines up in shift_r[7:0] after byte 0.
                if (tick_s) begin
                    shift_next_s   = {1'b0, shift_r[15:1]};
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = STOP;
                        tx_next_s    = 1'b1;
                    end else begin
                        tx_next_s = shift_r[1];
                    end
                end else begin
                    tx_next_s = shift_r[0];
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (byte_idx_r == 1'b0) begin
                        byte_idx_next_s = 1'b1;
                        state_next_s    = START;
                        tx_next_s       = 1'b0;
                    end else begin
                        state_next_s = IDLE;
                        tx_next_s    = 1'b1;
                    end
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
    end

    // State, datapath and registered handshake/line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 1'b0;
            shift_r    <= 16'h0000;
            tx_r       <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            byte_idx_r <= byte_idx_next_s;
            shift_r    <= shift_next_s;
            tx_r       <= tx_next_s;
            ready_r    <= (state_next_s == IDLE);
            busy_r     <= (state_next_s != IDLE);
        end
    end

    assign in_ready = ready_r;
    assign busy     = busy_r;
    assign tx       = tx_r;

endmodule

// File: tb/tb_hack_uart_tx.sv
// Scoreboard bench: accepted words are queued; a line monitor decodes tx and checks every cycle.
module tb_hack_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 20 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready, tx, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_at = 0;
    int acc_cnt = 0;
    int acc_edges[$];
    logic [15:0] exp_q[$];
    bit          in_frame = 1'b0;

    hack_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit n of a word's 20-bit line image: start, 8 data LSB first, stop, for each byte.
    function automatic logic frame_bit(input logic [15:0] w, input int n);
        logic [7:0] b;
        int k;
        b = (n < 10) ? w[7:0] : w[15:8];
        k = n % 10;
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return b[k-1];
    endfunction

    // Handshake model, accept scoreboard and line monitor, all sampled on the falling edge.
    initial begin
        logic [15:0] cur;
        int pos, lows, exp_lows;
        logic model_ready, eb;
        forever begin
            @(negedge clk);
            model_ready = (cyc >= ready_at);
            checks++;
            if (in_ready !== model_ready) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, model_ready);
            end
            checks++;
            if (busy !== !model_ready) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, !model_ready);
            end
            if (!rst_n) begin
                if (ready_at > cyc + 1) ready_at = cyc + 1;
            end else if (in_valid && model_ready) begin
                exp_q.push_back(din);
                ready_at = cyc + 1 + FRAME;
                acc_edges.push_back(cyc + 1);
                acc_cnt++;
            end

            if (!in_frame) begin
                if (tx === 1'b0 && exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    pos = 0;
                    lows = 1;
                    in_frame = rst_n;
                end else begin
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL idle_tx cyc=%0d got=%b want=1", cyc, tx);
                    end
                end
            end else begin
                pos++;
                eb = frame_bit(cur, pos / CPB);
                checks++;
                if (tx !== eb) begin
                    errors++;
                    $display("FAIL frame_bit word=%h cyc=%0d pos=%0d got=%b want=%b", cur, cyc, pos, tx, eb);
                end
                if (tx === 1'b0) lows++;
                if (!rst_n) begin
                    in_frame = 1'b0;
                end else if (pos == FRAME - 1) begin
                    in_frame = 1'b0;
                    exp_lows = CPB * (2 + 16 - $countones(cur));
                    checks++;
                    if (lows != exp_lows) begin
                        errors++;
                        $display("FAIL low_cycles word=%h got=%0d want=%0d", cur, lows, exp_lows);
                    end
                end
            end
        end
    end

    // Present a word and wait for the accept edge; returns just after that edge.
    task automatic send(input logic [15:0] w, input bit hold);
        int prev, n;
        prev = acc_cnt;
        din = w;
        in_valid = 1'b1;
        n = 0;
        while (acc_cnt == prev && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (acc_cnt == prev) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout word=%h got=none want=accept", w);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((in_frame || exp_q.size() != 0 || cyc < ready_at) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
    endtask

    initial begin
        int d;
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send(16'hA55A, 1'b0);
        wait_idle();

        send(16'h0001, 1'b1);
        send(16'hFFFF, 1'b0);
        checks++;
        if (acc_edges[acc_edges.size()-1] - acc_edges[acc_edges.size()-2] != FRAME + 1) begin
            errors++;
            $display("FAIL b2b_gap got=%0d want=%0d",
                     acc_edges[acc_edges.size()-1] - acc_edges[acc_edges.size()-2], FRAME + 1);
        end
        wait_idle();

        send(16'($urandom), 1'b0);
        repeat (70) begin
            din = 16'($urandom);
            in_valid = 1'($urandom % 2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        send(16'hC3A5, 1'b0);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h1234, 1'b0);
        wait_idle();

        rst_n = 1'b0;
        in_valid = 1'b1;
        din = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send(16'h0000, 1'b0);
        wait_idle();
        send(16'hFFFF, 1'b0);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            send(16'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_words got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_uart_tx.md
# hack_uart_tx

Serial transmitter that takes 16-bit Hack words from the core and sends each one on a single UART line as two 8N1 bytes, low byte first. It is the outbound end of the board's serial link, the counterpart of the word receiver used for program loading. It sits between the memory-mapped output register and the FPGA TX pin. Data is registered and never inverted: line level equals bit value, with idle high.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset. It is sampled on the clk rising edge.
- in  input  16  word to transmit; sampled only on an accept edge.
- in_valid  input  1  producer holds a word on `in`.
- in_ready  output  1  block can accept a word this cycle.
- tx  output  1  UART line, registered, idle high.
- busy  output  1  high from the accept edge until the frame completes.

## Operation
- Accept occurs on a clk edge where in_valid && in_ready.
  - `in` is latched into a 16-bit shift register.
  - Byte index is cleared to 0.
- States:
  - IDLE: in_ready=1, tx=1. Accept moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte index 0: set index to 1 and go to START (byte = in[15:8]);
    - byte index 1: go to IDLE.
- Byte 0 = in[7:0]; byte 1 = in[15:8].
- Bit timer:
  - counts 0..CLKS_PER_BIT-1;
  - reloads to 0 on every state/bit transition;
  - is held at 0 in IDLE.
- Bit counter is 3 bits and wraps 7→0 on DATA exit.
- in_ready = (state == IDLE). busy = !in_ready.
- in_valid while not in_ready is ignored. The producer must hold the word; no word is dropped or duplicated.
- Changes to `in` after accept have no effect on the frame in flight.

## Timing
- Reset values: tx=1, in_ready=1, busy=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame:
  - at the next edge tx=1 and state=IDLE;
  - the word is abandoned and no partial byte is completed.
- Accept at edge k:
  - tx=0 from edge k (registered output, zero added latency);
  - in_ready=0 from edge k.
- Bit n of the frame (n=0 start, 1..8 data, 9 stop, then 10..19 for byte 1) is driven on edges k+n·CLKS_PER_BIT through k+(n+1)·CLKS_PER_BIT-1.
- No idle gap between byte 0 stop and byte 1 start.
- IDLE is entered at edge k+20·CLKS_PER_BIT, and in_ready=1 from then.
- Earliest next accept is the following edge. Minimum word period is therefore 20·CLKS_PER_BIT+1 cycles, with tx high in the gap cycle.
- in_valid and reset asserted together: reset wins and nothing is accepted.

## Structure
- Shared package hack_uart_pkg holds:
  - state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - FRAME_BITS=10;
  - DEFAULT_CLKS_PER_BIT=434.
- The receiver imports the same package.
- Sub-module hack_baud_tick, parameterised by CLKS_PER_BIT:
  - synchronous-clear counter emitting a one-cycle `tick` on count CLKS_PER_BIT-1;
  - shared with the receiver.
- The top level holds the FSM, the shift register, the byte index and the tx register.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold rst_n=0 for 3 cycles → tx=1, in_ready=1, busy=0. Release → unchanged while in_valid=0.
- Single word: send in=16'hA55A, accept at edge k.
  - Byte 0 (5A) tx samples at mid-bit: 0,0,1,0,1,1,0,1,0,1. Byte 1 (A5): 0,1,0,1,0,0,1,0,1,1.
  - in_ready returns at edge k+80.
- Back-to-back: in_valid held high with 16'h0001 then 16'hFFFF → second accept at edge k+81; exactly one idle-high cycle between frames; both words decode correctly.
- Stall: toggle `in` and in_valid during a frame → no extra accept; frame bits match the word latched at accept.
- Reset mid-frame: pull rst_n low at edge k+30, during byte 0 DATA.
  - tx=1 and in_ready=1 at the next edge.
  - A new word 16'h1234 after release transmits fully and correctly.
- Boundary: in=16'h0000 → tx low for 9 bits per byte (36 cycles) with a 4-cycle stop high. in=16'hFFFF → tx low only during the two start bits.
